// File: rtl/hilo_muldiv_pkg.sv
// Shared types and constants for the HI/LO multiply/divide unit.
package hilo_muldiv_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBusy = 2'd1,
        StDone = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        OpMult  = 2'd0,
        OpMultu = 2'd1,
        OpDiv   = 2'd2,
        OpDivu  = 2'd3
    } op_e;

    localparam int unsigned IterCount = 32;
    localparam logic [4:0]  LastIter  = 5'(IterCount - 1);

    // Magnitude of v when treated as signed, otherwise v unchanged.
    function automatic logic [31:0] abs_if(input logic [31:0] v, input logic sgn);
        return (sgn && v[31]) ? -v : v;
    endfunction

endpackage

// File: rtl/div_iter.sv
// One restoring-divide step: shift the next dividend bit into the partial remainder and subtract.
module div_iter (
    input  logic [31:0] rem,
    input  logic [31:0] quo,
    input  logic [31:0] divisor,
    output logic [31:0] rem_next,
    output logic [31:0] quo_next
);

    logic [32:0] shifted;
    logic [32:0] diff;
    logic        borrow;

    always_comb begin
        shifted  = {rem, quo[31]};
        diff     = shifted - {1'b0, divisor};
        // Partial remainder stays below the divisor, so bit 32 is a clean borrow flag.
        borrow   = diff[32];
        rem_next = borrow ? shifted[31:0] : diff[31:0];
        quo_next = {quo[30:0], ~borrow};
    end

endmodule

// File: rtl/hilo_muldiv.sv
// HI/LO owner with a 32-step iterative multiply/divide engine that stalls EX until commit.
// Build option MULDIV_FAST_MULT_EN: mult/multu complete with a single-cycle multiplier.
module hilo_muldiv
    import hilo_muldiv_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        issue,
    input  logic        flush,
    input  logic        is_mult,
    input  logic        is_multu,
    input  logic        is_div,
    input  logic        is_divu,
    input  logic        hi_wen,
    input  logic        lo_wen,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic        stall,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    state_e      state_q;
    op_e         op_q;
    op_e         req_op;
    logic [4:0]  count_q;
    logic        neg_q;
    logic        rneg_q;
    logic        dz_q;
    logic [31:0] opnd_q;
    logic [63:0] acc_q;
    logic        busy_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;

    logic        req;
    logic        req_signed;
    logic        req_is_mul;
    logic        fast_go;
    logic [31:0] fast_hi;
    logic [31:0] fast_lo;
    logic [32:0] add_sum;
    logic [31:0] div_rem;
    logic [31:0] div_quo;
    logic [63:0] acc_step;
    logic [63:0] prod;
    logic [31:0] res_hi;
    logic [31:0] res_lo;

    assign req   = issue & ~flush & (is_mult | is_multu | is_div | is_divu);
    assign stall = req & (state_q != StDone);
    assign busy  = busy_q;
    assign hi    = hi_q;
    assign lo    = lo_q;

    always_comb begin
        req_op = OpDivu;
        if (is_mult)       req_op = OpMult;
        else if (is_multu) req_op = OpMultu;
        else if (is_div)   req_op = OpDiv;
        req_signed = is_mult | is_div;
        req_is_mul = is_mult | is_multu;
    end

`ifdef MULDIV_FAST_MULT_EN
    logic signed [32:0] fast_a;
    logic signed [32:0] fast_b;
    logic signed [65:0] fast_prod;
    logic               unused_fast;

    always_comb begin
        fast_a    = {is_mult & rs_data[31], rs_data};
        fast_b    = {is_mult & rt_data[31], rt_data};
        fast_prod = fast_a * fast_b;
        fast_hi   = fast_prod[63:32];
        fast_lo   = fast_prod[31:0];
        fast_go   = req_is_mul;
    end
    assign unused_fast = ^fast_prod[65:64];
`else
    assign fast_go = 1'b0;
    assign fast_hi = '0;
    assign fast_lo = '0;
`endif

    div_iter u_div_iter (
        .rem      (acc_q[63:32]),
        .quo      (acc_q[31:0]),
        .divisor  (opnd_q),
        .rem_next (div_rem),
        .quo_next (div_quo)
    );

    always_comb begin
        // Shift-add step: conditionally add multiplicand to the upper half, shift right.
        add_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
        acc_step = (op_q == OpDiv || op_q == OpDivu) ? {div_rem, div_quo}
                                                     : {add_sum, acc_q[31:1]};
        prod     = neg_q ? -acc_step : acc_step;
        if (op_q == OpMult || op_q == OpMultu) begin
            res_hi = prod[63:32];
            res_lo = prod[31:0];
        end else if (dz_q) begin
            res_hi = rs_data;
            res_lo = 32'hFFFF_FFFF;
        end else begin
            res_hi = rneg_q ? -acc_step[63:32] : acc_step[63:32];
            res_lo = neg_q  ? -acc_step[31:0]  : acc_step[31:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            op_q    <= OpMult;
            count_q <= '0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            dz_q    <= 1'b0;
            opnd_q  <= '0;
            acc_q   <= '0;
            busy_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (req && fast_go) begin
                        hi_q    <= fast_hi;
                        lo_q    <= fast_lo;
                        state_q <= StDone;
                        busy_q  <= 1'b1;
                    end else if (req) begin
                        op_q    <= req_op;
                        count_q <= '0;
                        dz_q    <= ~req_is_mul & (rt_data == 32'd0);
                        neg_q   <= req_signed & (rs_data[31] ^ rt_data[31]);
                        rneg_q  <= req_signed & rs_data[31];
                        if (req_is_mul) begin
                            opnd_q <= abs_if(rs_data, req_signed);
                            acc_q  <= {32'd0, abs_if(rt_data, req_signed)};
                        end else begin
                            opnd_q <= abs_if(rt_data, req_signed);
                            acc_q  <= {32'd0, abs_if(rs_data, req_signed)};
                        end
                        state_q <= StBusy;
                        busy_q  <= 1'b1;
                    end else begin
                        if (issue && hi_wen) hi_q <= rs_data;
                        if (issue && lo_wen) lo_q <= rs_data;
                    end
                end
                StBusy: begin
                    if (flush) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end else begin
                        acc_q   <= acc_step;
                        count_q <= count_q + 5'd1;
                        if (count_q == LastIter) begin
                            hi_q    <= res_hi;
                            lo_q    <= res_lo;
                            state_q <= StDone;
                        end
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_muldiv.sv
// Self-checking bench for hilo_muldiv: vector table of mult/div ops plus mthi, flush and reset sequences.
module tb_hilo_muldiv;

    logic        clk = 1'b0;
    logic        reset;
    logic        issue, flush;
    logic        is_mult, is_multu, is_div, is_divu;
    logic        hi_wen, lo_wen;
    logic [31:0] rs_data, rt_data;
    logic        stall, busy;
    logic [31:0] hi, lo;

    int checks   = 0;
    int failures = 0;

`ifdef MULDIV_FAST_MULT_EN
    localparam int MulStall = 1;
`else
    localparam int MulStall = 33;
`endif
    localparam int DivStall = 33;

    always #5 clk = ~clk;

    hilo_muldiv dut (
        .clk      (clk),
        .reset    (reset),
        .issue    (issue),
        .flush    (flush),
        .is_mult  (is_mult),
        .is_multu (is_multu),
        .is_div   (is_div),
        .is_divu  (is_divu),
        .hi_wen   (hi_wen),
        .lo_wen   (lo_wen),
        .rs_data  (rs_data),
        .rt_data  (rt_data),
        .stall    (stall),
        .busy     (busy),
        .hi       (hi),
        .lo       (lo)
    );

    typedef struct {
        string       name;
        logic [1:0]  op;   // 0 mult, 1 multu, 2 div, 3 divu
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] ehi;
        logic [31:0] elo;
        int          est;
    } vec_t;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", nm, act, exp);
        end
    endtask

    task automatic clear_inputs();
        issue = 0; flush = 0; is_mult = 0; is_multu = 0; is_div = 0; is_divu = 0;
        hi_wen = 0; lo_wen = 0;
    endtask

    task automatic drive_op(input logic [1:0] op, input logic [31:0] rs, input logic [31:0] rt);
        issue    = 1;
        is_mult  = (op == 2'd0);
        is_multu = (op == 2'd1);
        is_div   = (op == 2'd2);
        is_divu  = (op == 2'd3);
        rs_data  = rs;
        rt_data  = rt;
    endtask

    // Issue an op right after a posedge, count stall cycles until DONE, then release.
    task automatic run_op(input logic [1:0] op, input logic [31:0] rs, input logic [31:0] rt,
                          output int cyc);
        cyc = 0;
        @(posedge clk); #1;
        drive_op(op, rs, rt);
        forever begin
            @(negedge clk);
            if (!stall) break;
            cyc++;
            if (cyc > 200) begin
                check("stall_timeout", 32'(cyc), 32'd0);
                break;
            end
            @(posedge clk);
        end
        @(posedge clk); #1;
        clear_inputs();
        @(negedge clk);
    endtask

    vec_t vecs[12];

    initial begin
        int cyc;
        logic [31:0] save_hi, save_lo;

        vecs[0]  = '{"divu_100_7",     2'd3, 32'd100,      32'd7,        32'd2,        32'd14,       DivStall};
        vecs[1]  = '{"div_m7_2",       2'd2, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, DivStall};
        vecs[2]  = '{"div_min_m1",     2'd2, 32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h80000000, DivStall};
        vecs[3]  = '{"divu_5_0",       2'd3, 32'd5,        32'd0,        32'd5,        32'hFFFFFFFF, DivStall};
        vecs[4]  = '{"div_m16_0",      2'd2, 32'hFFFFFFF0, 32'd0,        32'hFFFFFFF0, 32'hFFFFFFFF, DivStall};
        vecs[5]  = '{"mult_m1_2",      2'd0, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFE, MulStall};
        vecs[6]  = '{"multu_ff_2",     2'd1, 32'hFFFFFFFF, 32'd2,        32'h1,        32'hFFFFFFFE, MulStall};
        vecs[7]  = '{"div_7_m2",       2'd2, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, DivStall};
        vecs[8]  = '{"mult_big_16",    2'd0, 32'h12345678, 32'h10,       32'h1,        32'h23456780, MulStall};
        vecs[9]  = '{"divu_ff_16",     2'd3, 32'hFFFFFFFF, 32'h10,       32'hF,        32'h0FFFFFFF, DivStall};
        vecs[10] = '{"mult_min_min",   2'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0,        MulStall};
        vecs[11] = '{"mult_m3_m5",     2'd0, 32'hFFFFFFFD, 32'hFFFFFFFB, 32'h0,        32'hF,        MulStall};

        clear_inputs();
        rs_data = '0;
        rt_data = '0;
        reset = 1;
        repeat (2) @(posedge clk);
        #1 reset = 0;
        @(negedge clk);
        check("reset_hi", hi, 32'h0);
        check("reset_lo", lo, 32'h0);
        check("reset_busy", {31'd0, busy}, 32'h0);
        check("reset_stall", {31'd0, stall}, 32'h0);

        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].op, vecs[i].rs, vecs[i].rt, cyc);
            check({vecs[i].name, "_stall"}, 32'(cyc), 32'(vecs[i].est));
            check({vecs[i].name, "_hi"}, hi, vecs[i].ehi);
            check({vecs[i].name, "_lo"}, lo, vecs[i].elo);
            check({vecs[i].name, "_busy"}, {31'd0, busy}, 32'h0);
        end

        // mthi: no stall, visible next cycle, lo untouched (lo is 0xF from the last vector).
        @(posedge clk); #1;
        issue = 1; hi_wen = 1; rs_data = 32'h12345678;
        @(negedge clk);
        check("mthi_stall", {31'd0, stall}, 32'h0);
        @(posedge clk); #1;
        clear_inputs();
        @(negedge clk);
        check("mthi_hi", hi, 32'h12345678);
        check("mthi_lo", lo, 32'hF);

        // mtlo
        @(posedge clk); #1;
        issue = 1; lo_wen = 1; rs_data = 32'hCAFEF00D;
        @(posedge clk); #1;
        clear_inputs();
        @(negedge clk);
        check("mtlo_lo", lo, 32'hCAFEF00D);
        check("mtlo_hi", hi, 32'h12345678);

        // Flush in the 10th BUSY cycle.
        save_hi = hi;
        save_lo = lo;
        @(posedge clk); #1;
        drive_op(2'd3, 32'd100, 32'd7);
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("flush_busy_before", {31'd0, busy}, 32'h1);
        check("flush_stall_before", {31'd0, stall}, 32'h1);
        flush = 1;
        @(posedge clk); #1;
        clear_inputs();
        @(negedge clk);
        check("flush_busy_after", {31'd0, busy}, 32'h0);
        check("flush_hi", hi, save_hi);
        check("flush_lo", lo, save_lo);
        repeat (40) @(posedge clk);
        @(negedge clk);
        check("flush_hi_later", hi, save_hi);

        // Reset pulsed mid-BUSY.
        @(posedge clk); #1;
        drive_op(2'd3, 32'd100, 32'd7);
        repeat (6) @(posedge clk);
        #2 reset = 1;
        #2;
        check("rst_mid_busy", {31'd0, busy}, 32'h0);
        check("rst_mid_hi", hi, 32'h0);
        check("rst_mid_lo", lo, 32'h0);
        clear_inputs();
        @(posedge clk); #1 reset = 0;
        @(negedge clk);
        check("rst_after_stall", {31'd0, stall}, 32'h0);

        // Engine still works after the reset.
        run_op(2'd3, 32'd100, 32'd7, cyc);
        check("post_rst_stall", 32'(cyc), 32'(DivStall));
        check("post_rst_lo", lo, 32'd14);
        check("post_rst_hi", hi, 32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
